// File: rtl/dac_serial_seq.sv
// dac_serial_seq: serial DAC word shifter with load/clear strobes and mux select; optional post-load settle via DAC_SEQ_SETTLE_EN.
module dac_serial_seq #(
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 2,
    parameter int LD_W       = 2,
    parameter int CLR_W      = 2,
    parameter int MUX_W      = 6,
    parameter int SETTLE_CYC = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [MUX_W-1:0]  s_mux,
    output logic              s_ready,
    input  logic              clr_req,
    output logic              dac_clk,
    output logic              dac_sdi,
    output logic              dac_ld_n,
    output logic              dac_clr_n,
    output logic [MUX_W-1:0]  mux_sel,
    output logic              busy,
    output logic              done
);
    localparam int M0      = CLK_DIV > LD_W ? CLK_DIV : LD_W;
    localparam int M1      = M0 > CLR_W ? M0 : CLR_W;
    localparam int CNT_MAX = M1 > SETTLE_CYC ? M1 : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

`ifdef DAC_SEQ_SETTLE_EN
    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, CLEAR, SETTLE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, CLEAR} state_t;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bits;
    logic [DATA_W-1:0] shreg;
    logic              clr_pend;

    assign s_ready = (state == IDLE) && !clr_req && !clr_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bits      <= '0;
            shreg     <= '0;
            dac_clk   <= 1'b1;
            dac_sdi   <= 1'b0;
            dac_ld_n  <= 1'b1;
            dac_clr_n <= 1'b1;
            mux_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr_req && state != IDLE) clr_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_req || clr_pend) begin
                        state     <= CLEAR;
                        dac_clr_n <= 1'b0;
                        cnt       <= CNT_W'(1);
                        busy      <= 1'b1;
                        clr_pend  <= 1'b0;
                    end else if (s_valid) begin
                        state   <= SHIFT;
                        shreg   <= s_data << 1;
                        dac_sdi <= s_data[DATA_W-1];
                        dac_clk <= 1'b0;
                        cnt     <= '0;
                        bits    <= '0;
                        mux_sel <= s_mux;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        // the end of the last high phase falls straight into the hold cycle
                        if (!dac_clk) dac_clk <= 1'b1;
                        else if (bits == BIT_W'(DATA_W - 1)) state <= LOAD;
                        else begin
                            bits    <= bits + 1'b1;
                            dac_clk <= 1'b0;
                            dac_sdi <= shreg[DATA_W-1];
                            shreg   <= shreg << 1;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                LOAD: begin
                    if (cnt == CNT_W'(LD_W)) begin
                        dac_ld_n <= 1'b1;
                        if (clr_pend || clr_req) begin
                            state     <= CLEAR;
                            dac_clr_n <= 1'b0;
                            cnt       <= CNT_W'(1);
                            clr_pend  <= 1'b0;
                        end else begin
`ifdef DAC_SEQ_SETTLE_EN
                            state <= SETTLE;
                            cnt   <= CNT_W'(1);
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end
                    end else begin
                        dac_ld_n <= 1'b0;
                        done     <= (cnt == CNT_W'(LD_W - 1));
                        cnt      <= cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == CNT_W'(CLR_W)) begin
                        dac_clr_n <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
`ifdef DAC_SEQ_SETTLE_EN
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC)) begin
                        if (clr_pend || clr_req) begin
                            state     <= CLEAR;
                            dac_clr_n <= 1'b0;
                            cnt       <= CNT_W'(1);
                            clr_pend  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else cnt <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_serial_seq.sv
// tb_dac_serial_seq: table-driven, hand-written and randomized checks of dac_serial_seq against a cycle-index model.
module tb_dac_serial_seq;
    localparam int D    = 12;
    localparam int CD   = 2;
    localparam int LW   = 2;
    localparam int CW   = 2;
    localparam int MW   = 6;
    localparam int F    = 2 * CD * D;
    localparam int POST = F + 2 + LW;
`ifdef DAC_SEQ_SETTLE_EN
    localparam int SC = 100;
`else
    localparam int SC = 0;
`endif

    logic          clk = 1'b0, reset = 1'b1, s_valid = 1'b0, clr_req = 1'b0;
    logic [D-1:0]  s_data = '0;
    logic [MW-1:0] s_mux = '0;
    logic          s_ready, dac_clk, dac_sdi, dac_ld_n, dac_clr_n, busy, done;
    logic [MW-1:0] mux_sel;
    logic [MW-1:0] last_mux = '0;

    int checks = 0, failures = 0;
    int rises = 0;
    logic [31:0] cap = '0;
    logic prev_clk = 1'b1;

    dac_serial_seq dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_mux(s_mux),
        .s_ready(s_ready), .clr_req(clr_req), .dac_clk(dac_clk), .dac_sdi(dac_sdi),
        .dac_ld_n(dac_ld_n), .dac_clr_n(dac_clr_n), .mux_sel(mux_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // observe what the DAC would latch: sdi on each rising dac_clk
    always @(posedge clk) begin
        if (dac_clk && !prev_clk) begin
            rises <= rises + 1;
            cap   <= {cap[30:0], dac_sdi};
        end
        prev_clk <= dac_clk;
    end

    typedef struct {
        logic [D-1:0]  data;
        logic [MW-1:0] mux;
        int            clr_t;
        logic [D-1:0]  exp_word;
        logic [MW-1:0] exp_mux;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // expected {dac_clk, ld_n, clr_n, busy, done, s_ready} t cycles after the accepting edge
    function automatic logic [5:0] model(input int t, input bit clr);
        int tail;
        logic c, ld, cn, b, dn;
        tail = clr ? CW : SC;
        c  = (t > F) || (((t - 1) % (2 * CD)) >= CD);
        ld = !(t >= F + 2 && t < POST);
        cn = !(clr && t >= POST && t < POST + CW);
        b  = t < POST + tail;
        dn = (t == POST - 1);
        return {c, ld, cn, b, dn, !b};
    endfunction

    task automatic send(input logic [D-1:0] d, input logic [MW-1:0] m, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        s_mux   = m;
        @(posedge clk);
        #1;
        if (!keep) s_valid = 1'b0;
        last_mux = m;
    endtask

    task automatic run_frame(input logic [D-1:0] word, input logic [MW-1:0] mux, input int clr_t, input bit keep);
        int r0 = rises;
        int nt = POST + (clr_t > 0 ? CW : SC);
        for (int t = 1; t <= nt; t++) begin
            @(negedge clk);
            clr_req = 1'b0;
            chk("frame_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {model(t, clr_t > 0), mux});
            if (t <= F) chk("frame_sdi", dac_sdi, word[D-1-(t-1)/(2*CD)]);
            if (t == clr_t) clr_req = 1'b1;
            if (!keep) begin
                s_data = D'($urandom);
                s_mux  = MW'($urandom);
            end
        end
        chk("rise_count", rises - r0, D);
        chk("shift_word", cap[D-1:0], word);
    endtask

    vec_t tbl[4];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int bad;
        tbl[0] = '{12'h555, 6'h02, 0,  12'h555, 6'h02};
        tbl[1] = '{12'hfff, 6'h3f, 0,  12'hfff, 6'h3f};
        tbl[2] = '{12'h000, 6'h00, 0,  12'h000, 6'h00};
        tbl[3] = '{12'h801, 6'h15, 10, 12'h801, 6'h15};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {6'b111001, 6'h00});
        chk("reset_sdi", dac_sdi, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {6'b111001, 6'h00});

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].data, tbl[i].mux, 1'b0);
            run_frame(tbl[i].exp_word, tbl[i].exp_mux, tbl[i].clr_t, 1'b0);
        end

        // back-to-back: valid held, next word presented mid-frame
        send(12'h3c5, 6'h11, 1'b1);
        s_data = 12'h9a6;
        s_mux  = 6'h2a;
        run_frame(12'h3c5, 6'h11, 0, 1'b1);
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        last_mux = 6'h2a;
        run_frame(12'h9a6, 6'h2a, 0, 1'b0);

        // clear and request together: clear first, word held and taken after
        @(negedge clk);
        clr_req = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'h6b3;
        s_mux   = 6'h07;
        #1;
        chk("clr_wins_ready", s_ready, 0);
        @(posedge clk);
        for (int t = 1; t <= CW; t++) begin
            @(negedge clk);
            clr_req = 1'b0;
            chk("idle_clear_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {6'b110100, last_mux});
        end
        @(negedge clk);
        chk("after_clear_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {6'b111001, last_mux});
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        last_mux = 6'h07;
        run_frame(12'h6b3, 6'h07, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [D-1:0]  d;
            logic [MW-1:0] m;
            int            ct;
            d  = D'($urandom);
            m  = MW'($urandom);
            ct = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, F)) : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(d, m, 1'b0);
            run_frame(d, m, ct, 1'b0);
        end

        // reset mid-frame aborts with no load strobe
        send(12'hace, 6'h1b, 1'b0);
        for (int t = 1; t <= 20; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_abort_vec", {dac_clk, dac_ld_n, dac_clr_n, busy, done, s_ready, mux_sel}, {6'b111001, 6'h00});
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || !dac_ld_n || busy) bad++;
        end
        chk("no_load_after_abort", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
